// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider with a register-file write port.
// It performs one restoring radix-2 step per cycle on the operand magnitudes.
//
// Parameters
//   EARLY_OUT : 1 = divide-by-zero and signed overflow finish straight from IDLE
//               0 = those cases take the normal 32-step path
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : begin a divide (sampled only in IDLE)
//   op       : 00=DIV 01=DIVU 10=REM 11=REMU
//   dividend : rs1 operand
//   divisor  : rs2 operand
//   rd       : destination register index
//   flush    : abort any in-flight operation without writeback
//   busy     : state is not IDLE
//   done     : one-cycle completion pulse
//   we/wa/wd : register-file write port (we suppressed for rd == 0)
module div_unit #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [4:0]          cnt;

  // Captured operation context and iteration datapath.
  logic [4:0]          rd_r;
  logic                sel_rem_r;
  logic                neg_q_r;
  logic                neg_r_r;
  logic                spec_r;
  logic [DATA_W-1:0]   spec_res_r;
  logic [DATA_W-1:0]   quo_r;
  logic [DATA_W-1:0]   rem_r;
  logic [DATA_W-1:0]   dvs_r;

  // Two's complement negate when cond is set (modulo 2^32).
  function automatic logic [DATA_W-1:0] neg_if(input logic cond, input logic [DATA_W-1:0] v);
    return cond ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Operand classification on the request inputs.
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic                     is_signed;
  logic                     a_neg;
  logic                     b_neg;
  logic                     div0;
  logic                     ovf;
  logic                     special;
  logic [DATA_W-1:0]        spec_val;
  logic                     accept;

  always_comb begin
    a_s       = signed'(dividend);
    b_s       = signed'(divisor);
    is_signed = ~op[0];
    a_neg     = is_signed & (a_s < 0);
    b_neg     = is_signed & (b_s < 0);
    div0      = (divisor == '0);
    ovf       = is_signed & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
    special   = div0 | ovf;
    // Fixed architectural results for the two special cases.
    if (div0)
      spec_val = op[1] ? dividend : 32'hFFFF_FFFF;
    else
      spec_val = op[1] ? 32'h0000_0000 : 32'h8000_0000;
    accept    = (state == IDLE) & start & ~flush;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The partial remainder is
  // always below the divisor, so 33 bits hold the shifted value.
  logic [DATA_W:0]   shl;
  logic [DATA_W:0]   sub;
  logic              q_bit;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quo_nx;
  logic [DATA_W-1:0] res_fin;

  always_comb begin
    shl     = {rem_r, quo_r[DATA_W-1]};
    sub     = shl - {1'b0, dvs_r};
    q_bit   = ~sub[DATA_W];
    rem_nx  = q_bit ? sub[DATA_W-1:0] : shl[DATA_W-1:0];
    quo_nx  = {quo_r[DATA_W-2:0], q_bit};
    // Result as it will be after the step taken this cycle; used on the last step.
    if (spec_r)
      res_fin = spec_res_r;
    else if (sel_rem_r)
      res_fin = neg_if(neg_r_r, rem_nx);
    else
      res_fin = neg_if(neg_q_r, quo_nx);
  end

  assign busy = (state != IDLE);

  // Datapath: operand capture and iteration, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      quo_r      <= neg_if(a_neg, dividend);
      rem_r      <= '0;
      dvs_r      <= neg_if(b_neg, divisor);
      neg_q_r    <= a_neg ^ b_neg;
      neg_r_r    <= a_neg;
      spec_r     <= special;
      spec_res_r <= spec_val;
      sel_rem_r  <= op[1];
      rd_r       <= rd;
    end else if (state == CALC) begin
      quo_r      <= quo_nx;
      rem_r      <= rem_nx;
    end
  end

  // Control FSM with registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      we    <= 1'b0;
      wa    <= '0;
      wd    <= '0;
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (special && EARLY_OUT) begin
              state <= DONE;
              done  <= 1'b1;
              we    <= (rd != 5'd0);
              wa    <= rd;
              wd    <= spec_val;
            end else begin
              state <= CALC;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= DONE;
              done  <= 1'b1;
              we    <= (rd_r != 5'd0);
              wa    <= rd_r;
              wd    <= res_fin;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd;

  logic        busy, done, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        busy0, done0, we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;

  int tests = 0;
  int fails = 0;

  div_unit #(.EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .rd(rd), .flush(flush), .busy(busy), .done(done),
    .we(we), .wa(wa), .wd(wd)
  );

  div_unit #(.EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .rd(rd), .flush(flush), .busy(busy0), .done(done0),
    .we(we0), .wa(wa0), .wd(wd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: architectural result from the arithmetic rules.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Presents a request for one cycle (caller is between edges), then watches
  // both instances until each has pulsed done; latency -1 means no pulse.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, output int l1, output int l0,
                        output logic [31:0] d1, output logic [31:0] d0,
                        output logic e1, output logic [4:0] w1);
    l1 = -1; l0 = -1; d1 = '0; d0 = '0; e1 = 1'b0; w1 = '0;
    op = o; dividend = a; divisor = b; rd = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done && l1 < 0) begin l1 = c; d1 = wd; e1 = we; w1 = wa; end
      if (done0 && l0 < 0) begin l0 = c; d0 = wd0; end
      if (l1 >= 0 && l0 >= 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; dividend = '0; divisor = '0; rd = '0;
    #1;
    tests++;
    if ({busy, done, we, wa, wd} !== 40'd0 || {busy0, done0, we0, wa0, wd0} !== 40'd0) begin
      fails++;
      $display("FAIL reset outputs act=%b_%b_%b_%h_%h exp=0_0_0_00_00000000", busy, done, we, wa, wd);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  vo [10];
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [4:0]  vr [10];
    logic [31:0] vq [10];
    int l1, l0;
    logic [31:0] d1, d0;
    logic e1;
    logic [4:0] w1;
    vo = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    va = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1234, 32'd1234, 32'h8000_0000,
           32'h8000_0000, 32'd9, 32'hFFFF_FFF9, 32'h8000_0000};
    vb = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'hFFFF_FFFF};
    vr = '{5'd5, 5'd3, 5'd3, 5'd7, 5'd8, 5'd9, 5'd10, 5'd0, 5'd11, 5'd12};
    vq = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1234, 32'h8000_0000,
           32'd0, 32'd3, 32'hFFFF_FFF9, 32'd0};
    for (int i = 0; i < 10; i++) begin
      run_op(vo[i], va[i], vb[i], vr[i], l1, l0, d1, d0, e1, w1);
      tests++;
      if (d1 !== vq[i]) begin fails++; $display("FAIL dir%0d wd act=%h exp=%h", i, d1, vq[i]); end
      tests++;
      if (d0 !== vq[i]) begin fails++; $display("FAIL dir%0d wd_noearly act=%h exp=%h", i, d0, vq[i]); end
      tests++;
      if (l1 != exp_lat(vo[i], va[i], vb[i])) begin
        fails++; $display("FAIL dir%0d latency act=%0d exp=%0d", i, l1, exp_lat(vo[i], va[i], vb[i]));
      end
      tests++;
      if (l0 != 33) begin fails++; $display("FAIL dir%0d latency_noearly act=%0d exp=33", i, l0); end
      tests++;
      if (e1 !== (vr[i] != 5'd0) || w1 !== vr[i]) begin
        fails++; $display("FAIL dir%0d we/wa act=%b/%0d exp=%b/%0d", i, e1, w1, vr[i] != 5'd0, vr[i]);
      end
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0 || busy0 !== 1'b0 || done !== 1'b0 || done0 !== 1'b0 || we !== 1'b0) begin
        fails++; $display("FAIL dir%0d after_done busy=%b/%b done=%b/%b we=%b exp all 0", i, busy, busy0, done, done0, we);
      end
      tests++;
      if (wd !== vq[i] || wa !== vr[i]) begin
        fails++; $display("FAIL dir%0d hold wa/wd act=%0d/%h exp=%0d/%h", i, wa, wd, vr[i], vq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [31:0] a, b, q;
    logic [4:0] r;
    int l1, l0;
    logic [31:0] d1, d0;
    logic e1;
    logic [4:0] w1;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      r = 5'($urandom_range(0, 31));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      q = model(o, a, b);
      run_op(o, a, b, r, l1, l0, d1, d0, e1, w1);
      tests++;
      if (d1 !== q || d0 !== q || l1 != exp_lat(o, a, b) || l0 != 33 || e1 !== (r != 5'd0) || w1 !== r) begin
        fails++;
        $display("FAIL rnd%0d op=%0d a=%h b=%h rd=%0d act wd=%h/%h lat=%0d/%0d we=%b wa=%0d exp wd=%h lat=%0d/33",
                 i, o, a, b, r, d1, d0, l1, l0, e1, w1, q, exp_lat(o, a, b));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    int pulses;
    int l1, l0;
    logic [31:0] d1, d0;
    logic e1;
    logic [4:0] w1;
    pulses = 0;
    op = 2'b01; dividend = 32'd1000; divisor = 32'd10; rd = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done || we) pulses++;
      @(posedge clk); #1;
    end
    flush = 1'b1;                       // cycle 10
    if (done || we) pulses++;
    @(posedge clk); #1;                 // cycle 11
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || busy0 !== 1'b0 || done !== 1'b0 || we !== 1'b0 || pulses != 0) begin
      fails++; $display("FAIL flush_calc busy=%b/%b done=%b we=%b pulses=%0d exp 0", busy, busy0, done, we, pulses);
    end
    @(posedge clk); #1;                 // cycle 12
    run_op(2'b01, 32'd77, 32'd5, 5'd6, l1, l0, d1, d0, e1, w1);
    tests++;
    if (l1 != 33 || d1 !== 32'd15 || d0 !== 32'd15) begin
      fails++; $display("FAIL flush_restart act lat=%0d wd=%h/%h exp lat=33 wd=0000000f", l1, d1, d0);
    end
    @(posedge clk); #1;
    // flush together with start in IDLE: nothing captured
    pulses = 0;
    op = 2'b01; dividend = 32'd50; divisor = 32'd0; rd = 5'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (busy || busy0 || done || done0 || we) pulses++;
      @(posedge clk); #1;
    end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL flush_start active_cycles act=%0d exp=0", pulses); end
  endtask

  task automatic test_start_ignored();
    int l1, l0;
    logic [31:0] d1, d0;
    logic e1;
    logic [4:0] w1;
    l1 = -1; d1 = '0;
    op = 2'b00; dividend = 32'hFFFF_FF38; divisor = 32'd9; rd = 5'd13; start = 1'b1;   // -200/9
    @(posedge clk); #1;
    op = 2'b11; dividend = 32'd5; divisor = 32'd0; rd = 5'd1;   // start stays high in CALC and DONE
    for (int c = 1; c <= 40; c++) begin
      if (done) begin l1 = c; d1 = wd; w1 = wa; break; end
      @(posedge clk); #1;
    end
    tests++;
    if (l1 != 33 || d1 !== 32'hFFFF_FFEA || w1 !== 5'd13) begin
      fails++; $display("FAIL start_ignored act lat=%0d wd=%h wa=%0d exp lat=33 wd=ffffffea wa=13", l1, d1, w1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_in_done busy act=%b exp=0", busy); end
    // let the other instance drain if it caught anything
    for (int c = 0; c < 40; c++) begin
      if (!busy0) break;
      @(posedge clk); #1;
    end
    l0 = 0; d0 = '0; e1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    int l1, l0;
    logic [31:0] d1, d0;
    logic e1;
    logic [4:0] w1;
    pulses = 0;
    op = 2'b01; dividend = 32'd9999; divisor = 32'd3; rd = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (done || we) pulses++;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;                    // cycle 20, between edges
    #1;
    tests++;
    if ({busy, done, we, wa, wd} !== 40'd0 || busy0 !== 1'b0 || pulses != 0) begin
      fails++; $display("FAIL reset_mid act busy=%b done=%b we=%b wa=%0d wd=%h pulses=%0d exp all 0", busy, done, we, wa, wd, pulses);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 5'd17, l1, l0, d1, d0, e1, w1);   // 100 rem -7 = 2
    tests++;
    if (l1 != 33 || d1 !== 32'd2 || d0 !== 32'd2 || e1 !== 1'b1 || w1 !== 5'd17) begin
      fails++; $display("FAIL reset_restart act lat=%0d wd=%h/%h we=%b wa=%0d exp lat=33 wd=00000002 we=1 wa=17", l1, d1, d0, e1, w1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
